lsu_mem_requester: RTL and testbench
====================================

LSU_MEM_REQUESTER -- requirements
Module: lsu_mem_requester

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, memory address width in bits.
REQ-003 SHALL have parameter NUM_CHANNELS, default 8, number of lanes, one memory channel per lane.
REQ-004 SHALL have parameter RESP_LATENCY, default 2, cycles from read handshake to valid mem_resp_data; legal range 1..15.
REQ-005 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit, batch request strobe.
REQ-008 SHALL have port start_ready, output, 1 bit, high when a start can be accepted.
REQ-009 SHALL have port op_write, input, 1 bit, batch is a store (1) or a load (0).
REQ-010 SHALL have port lane_mask, input, NUM_CHANNELS bits, active lanes.
REQ-011 SHALL have port lane_addr, input, ADDR_WIDTH x NUM_CHANNELS unpacked, per-lane address.
REQ-012 SHALL have port lane_wdata, input, DATA_WIDTH x NUM_CHANNELS unpacked, per-lane store data.
REQ-013 SHALL have port lane_rdata, output, DATA_WIDTH x NUM_CHANNELS unpacked, per-lane load result.
REQ-014 SHALL have port done, output, 1 bit, one-cycle batch-complete pulse.
REQ-015 SHALL have ports mem_req_valid (output), mem_req_ready (input), mem_w_valid (output), mem_w_ready (input), each NUM_CHANNELS bits; read and write handshakes.
REQ-016 SHALL have ports mem_req_addr (output, ADDR_WIDTH x N), mem_w_data (output, DATA_WIDTH x N) and mem_resp_data (input, DATA_WIDTH x N).

Function
REQ-017 SHALL implement a top FSM with states IDLE, RUN and DONE; start_ready SHALL be high only in IDLE.
REQ-018 SHALL accept start only when start and start_ready are both high in cycle T, latching op_write, lane_mask, lane_addr and lane_wdata, clearing all lane_rdata to 0, and entering RUN at T+1.
REQ-019 SHALL ignore start outside IDLE; no latch and no state change.
REQ-020 SHALL give each lane its own state: PENDING, WAIT_RESP or COMPLETE. Masked-off lanes SHALL enter COMPLETE at start acceptance; active lanes SHALL enter PENDING.
REQ-021 SHALL, in RUN, drive mem_req_addr[i] with the latched address for every PENDING lane. For a load it SHALL assert mem_req_valid[i]; for a store it SHALL assert mem_w_valid[i] with mem_w_data[i]. Valid SHALL rise at T+1 at the earliest.
REQ-022 SHALL hold valid, address and data stable until the handshake (valid and ready high together); valid SHALL NOT be withdrawn early.
REQ-023 SHALL move a store lane to COMPLETE in the cycle after its handshake.
REQ-024 SHALL move a load lane handshaken in cycle H to WAIT_RESP. A per-lane counter SHALL capture mem_resp_data[i] into lane_rdata[i] in cycle H+RESP_LATENCY, and the lane SHALL become COMPLETE.
REQ-025 SHALL never assert mem_req_valid and mem_w_valid together on the same lane, and SHALL issue at most one request per lane per batch.
REQ-026 SHALL move RUN to DONE in the cycle after all lanes reach COMPLETE. done SHALL be high for exactly the one DONE cycle, then the FSM SHALL return to IDLE.
REQ-027 SHALL handle an all-zero lane_mask with no memory requests: start at T, done at T+2.
REQ-028 SHALL hold lane_rdata stable from done until the next accepted start.
REQ-029 SHALL tolerate simultaneous handshakes on several lanes and handshakes in arbitrary order; each lane completes independently.

Reset
REQ-030 SHALL, on reset, put the FSM in IDLE and all lanes in COMPLETE. All valids, done and lane_rdata SHALL be 0; start_ready SHALL be 1 in the cycle after reset.
REQ-031 SHALL, on reset asserted mid-batch, abandon the batch: valids drop the next cycle, no done, and responses already in flight are discarded.

Structure
REQ-032 SHALL place the lane-state enum, the FSM-state enum and the latency-counter width constant in shared package fdga_mem_pkg.
REQ-033 SHALL implement per-lane tracking (lane state, counter, capture register) as sub-module mem_lane_tracker, instantiated NUM_CHANNELS times.

Verification
REQ-034 SHALL cover a load: mask 8'h05, addr 0x10 and 0x20, ready tied high, responses 0xAAAA and 0xBBBB two cycles after handshake -> lane_rdata[0]=0xAAAA, lane_rdata[2]=0xBBBB, single done pulse.
REQ-035 SHALL cover a store: mask 8'hFF with mem_w_ready granted round-robin one lane per cycle -> exactly 8 write handshakes with correct addr/data, done after the last.
REQ-036 SHALL cover mask 8'h00 -> no valids, done exactly 2 cycles after start.
REQ-037 SHALL cover backpressure: mem_req_ready low for 5 cycles on lane 3 -> valid and address held stable all 5 cycles, lane completes after grant.
REQ-038 SHALL cover start asserted during RUN -> ignored, latched inputs unchanged.
REQ-039 SHALL cover reset asserted two cycles into a load batch -> valids 0 next cycle, no done, start_ready 1 after reset.

Source files
------------

// File: rtl/fdga_mem_pkg.sv
// Shared types for the LSU memory requester: FSM and lane-state encodings
// plus the width of the per-lane response-latency counter.
package fdga_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  typedef enum logic [1:0] {
    LANE_PENDING   = 2'd0,
    LANE_WAIT_RESP = 2'd1,
    LANE_COMPLETE  = 2'd2
  } lane_state_e;

  // Wide enough for RESP_LATENCY-1 with RESP_LATENCY up to 15.
  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/mem_lane_tracker.sv
// One lane of a batch: issues a single read or write request, waits out the
// fixed response latency for loads, and holds the captured load result.
module mem_lane_tracker
  import fdga_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int RESP_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  accept,
  input  logic                  active,
  input  logic                  op_write,
  input  logic                  req_ready,
  input  logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] resp_data,
  output logic                  req_valid,
  output logic                  w_valid,
  output logic                  complete,
  output logic [DATA_WIDTH-1:0] rdata,
  output lane_state_e           state
);

  localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(RESP_LATENCY - 1);

  lane_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      LANE_PENDING: begin
        if (op_write && w_ready) begin
          state_d = LANE_COMPLETE;
        end else if (!op_write && req_ready) begin
          state_d = LANE_WAIT_RESP;
          cnt_d   = CNT_LOAD;
        end
      end
      LANE_WAIT_RESP: begin
        // cnt_q reaches zero exactly RESP_LATENCY cycles after the handshake.
        if (cnt_q == '0) begin
          rdata_d = resp_data;
          state_d = LANE_COMPLETE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
    // Accept only happens in IDLE, when every lane is already COMPLETE.
    if (accept) begin
      state_d = active ? LANE_PENDING : LANE_COMPLETE;
      cnt_d   = '0;
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LANE_COMPLETE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_valid = (state_q == LANE_PENDING) && !op_write;
  assign w_valid   = (state_q == LANE_PENDING) && op_write;
  assign complete  = (state_q == LANE_COMPLETE);
  assign rdata     = rdata_q;
  assign state     = state_q;

endmodule

// File: rtl/lsu_mem_requester.sv
// Batch memory requester: latches a per-lane load/store batch on start,
// drives one memory channel per lane and pulses done once all lanes finish.
module lsu_mem_requester
  import fdga_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int NUM_CHANNELS = 8,
  parameter int RESP_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  start_ready,
  input  logic                  op_write,
  input  logic [NUM_CHANNELS-1:0] lane_mask,
  input  logic [ADDR_WIDTH-1:0] lane_addr  [NUM_CHANNELS],
  input  logic [DATA_WIDTH-1:0] lane_wdata [NUM_CHANNELS],
  output logic [DATA_WIDTH-1:0] lane_rdata [NUM_CHANNELS],
  output logic                  done,
  output logic [NUM_CHANNELS-1:0] mem_req_valid,
  input  logic [NUM_CHANNELS-1:0] mem_req_ready,
  output logic [NUM_CHANNELS-1:0] mem_w_valid,
  input  logic [NUM_CHANNELS-1:0] mem_w_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr  [NUM_CHANNELS],
  output logic [DATA_WIDTH-1:0] mem_w_data    [NUM_CHANNELS],
  input  logic [DATA_WIDTH-1:0] mem_resp_data [NUM_CHANNELS],
  output fsm_state_e            dbg_state,
  output lane_state_e           dbg_lane_state [NUM_CHANNELS]
);

  // Handshakes: a transfer happens in any cycle where valid and ready are both
  // high; once raised, valid, address and data stay put until that cycle, and
  // ready may toggle freely without affecting them.

  fsm_state_e            state_q, state_d;
  logic                  op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0] addr_q  [NUM_CHANNELS];
  logic [ADDR_WIDTH-1:0] addr_d  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] wdata_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] wdata_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] lane_complete;
  logic                  accept;

  assign accept = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (&lane_complete) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_write_d = accept ? op_write : op_write_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      addr_d[i]  = accept ? lane_addr[i]  : addr_q[i];
      wdata_d[i] = accept ? lane_wdata[i] : wdata_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_write_q <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        addr_q[i]  <= addr_d[i];
        wdata_q[i] <= wdata_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
    mem_lane_tracker #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESP_LATENCY(RESP_LATENCY)
    ) u_tracker (
      .clk      (clk),
      .reset    (reset),
      .accept   (accept),
      .active   (lane_mask[g]),
      .op_write (op_write_q),
      .req_ready(mem_req_ready[g]),
      .w_ready  (mem_w_ready[g]),
      .resp_data(mem_resp_data[g]),
      .req_valid(mem_req_valid[g]),
      .w_valid  (mem_w_valid[g]),
      .complete (lane_complete[g]),
      .rdata    (lane_rdata[g]),
      .state    (dbg_lane_state[g])
    );
    assign mem_req_addr[g] = addr_q[g];
    assign mem_w_data[g]   = wdata_q[g];
  end

  assign start_ready = (state_q == ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_lsu_mem_requester.sv
// Directed bench for lsu_mem_requester: expected handshakes and batch results
// are queued by the stimulus and checked by an independent monitor.
module tb_lsu_mem_requester;
  import fdga_mem_pkg::*;

  localparam int DW = 32, AW = 32, N = 8, LAT = 2;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, op_write = 1'b0;
  logic start_ready, done;
  logic [N-1:0] lane_mask = '0;
  logic [AW-1:0] lane_addr [N];
  logic [DW-1:0] lane_wdata [N];
  logic [DW-1:0] lane_rdata [N];
  logic [N-1:0] mem_req_valid, mem_w_valid;
  logic [N-1:0] mem_req_ready = '0, mem_w_ready = '0;
  logic [AW-1:0] mem_req_addr [N];
  logic [DW-1:0] mem_w_data [N];
  logic [DW-1:0] mem_resp_data [N];
  fsm_state_e dbg_state;
  lane_state_e dbg_lane_state [N];

  logic [67:0]  exp_hs_q[$];
  logic [255:0] exp_done_q[$];
  logic [DW-1:0] resp_val [N];
  int resp_cnt [N] = '{default: 0};
  int n_vec = 0, n_err = 0, done_cnt = 0;

  always #5 clk = ~clk;

  lsu_mem_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CHANNELS(N), .RESP_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
    .op_write(op_write), .lane_mask(lane_mask), .lane_addr(lane_addr),
    .lane_wdata(lane_wdata), .lane_rdata(lane_rdata), .done(done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready),
    .mem_req_addr(mem_req_addr), .mem_w_data(mem_w_data),
    .mem_resp_data(mem_resp_data), .dbg_state(dbg_state),
    .dbg_lane_state(dbg_lane_state)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [67:0] mk_hs(input logic w, input int lane, input logic [31:0] a, input logic [31:0] d);
    return {w, 3'(lane), a, d};
  endfunction

  function automatic logic [255:0] pack_rdata();
    logic [255:0] r;
    for (int i = 0; i < N; i++) r[32*i +: 32] = lane_rdata[i];
    return r;
  endfunction

  // Monitor: every handshake and every done pulse consumes one expectation.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        if (mem_req_valid[i] && mem_w_valid[i]) begin
          n_vec++; n_err++;
          $display("FAIL both_valid lane %0d: got 1 expected 0", i);
        end
        if ((mem_req_valid[i] && mem_req_ready[i]) || (mem_w_valid[i] && mem_w_ready[i])) begin
          if (exp_hs_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_handshake lane %0d: got handshake expected none", i);
          end else begin
            check("handshake", {188'h0, mem_w_valid[i], 3'(i), mem_req_addr[i],
                                (mem_w_valid[i] ? mem_w_data[i] : 32'h0)},
                  {188'h0, exp_hs_q.pop_front()});
          end
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done expected none at %0t", $time);
        end else begin
          check("done_rdata", pack_rdata(), exp_done_q.pop_front());
        end
      end
    end
  end

  // Memory model: a load response is presented exactly LAT cycles after its handshake.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (resp_cnt[i] > 0) begin
        resp_cnt[i]--;
        mem_resp_data[i] = (resp_cnt[i] == 0) ? resp_val[i] : $urandom;
      end else begin
        mem_resp_data[i] = $urandom;
      end
      if (mem_req_valid[i] && mem_req_ready[i]) resp_cnt[i] = LAT;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic w, input logic [N-1:0] m);
    start = 1'b1; op_write = w; lane_mask = m;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (!start_ready && k < 200) begin tick(); k++; end
    check(name, start_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] exp_r;
    for (int i = 0; i < N; i++) begin
      lane_addr[i] = 32'h0; lane_wdata[i] = 32'h0; resp_val[i] = 32'hDEAD_0000 + i;
    end
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_start_ready", start_ready, 1'b1);
    check("reset_done", done, 1'b0);
    check("reset_valids", {mem_req_valid, mem_w_valid}, 16'h0);
    check("reset_rdata", pack_rdata(), 256'h0);
    for (int i = 0; i < N; i++) check("reset_lane_state", dbg_lane_state[i], LANE_COMPLETE);

    // Load, lanes 0 and 2, ready tied high.
    lane_addr[0] = 32'h10; lane_addr[2] = 32'h20;
    resp_val[0] = 32'hAAAA; resp_val[2] = 32'hBBBB;
    mem_req_ready = '1;
    exp_hs_q.push_back(mk_hs(1'b0, 0, 32'h10, 32'h0));
    exp_hs_q.push_back(mk_hs(1'b0, 2, 32'h20, 32'h0));
    exp_r = '0; exp_r[31:0] = 32'hAAAA; exp_r[95:64] = 32'hBBBB;
    exp_done_q.push_back(exp_r);
    do_start(1'b0, 8'h05);
    wait_idle("load_idle");
    repeat (3) tick();
    check("load_rdata_hold", pack_rdata(), exp_r);

    // Store, all lanes, write ready granted one lane per cycle.
    mem_req_ready = '0;
    for (int i = 0; i < N; i++) begin
      lane_addr[i] = 32'h100 + 4 * i; lane_wdata[i] = 32'hD000 + i;
      exp_hs_q.push_back(mk_hs(1'b1, i, 32'h100 + 4 * i, 32'hD000 + i));
    end
    exp_done_q.push_back(256'h0);
    do_start(1'b1, 8'hFF);
    for (int k = 0; k < N; k++) begin
      mem_w_ready = N'(1) << k;
      tick();
    end
    mem_w_ready = '0;
    wait_idle("store_idle");

    // Empty mask: done exactly two cycles after start.
    mem_req_ready = '1; mem_w_ready = '1;
    exp_done_q.push_back(256'h0);
    do_start(1'b0, 8'h00);
    check("zero_done_t1", done, 1'b0);
    check("zero_valids_t1", {mem_req_valid, mem_w_valid}, 16'h0);
    tick();
    check("zero_done_t2", done, 1'b1);
    check("zero_valids_t2", {mem_req_valid, mem_w_valid}, 16'h0);
    tick();
    check("zero_idle_t3", start_ready, 1'b1);
    mem_w_ready = '0;

    // Backpressure on lane 3, with a start attempt while running.
    lane_addr[3] = 32'h300; resp_val[3] = 32'h3333;
    mem_req_ready = 8'hF7;
    exp_hs_q.push_back(mk_hs(1'b0, 3, 32'h300, 32'h0));
    exp_r = '0; exp_r[127:96] = 32'h3333;
    exp_done_q.push_back(exp_r);
    do_start(1'b0, 8'h08);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", mem_req_valid[3], 1'b1);
      check("bp_addr", mem_req_addr[3], 32'h300);
      check("bp_no_wvalid", mem_w_valid, 8'h0);
      check("bp_start_ready", start_ready, 1'b0);
      start = (k == 1); op_write = (k == 1);
      lane_mask = (k == 1) ? 8'hFF : 8'h08;
      if (k == 1) lane_addr[3] = 32'h999;
      tick();
    end
    start = 1'b0; op_write = 1'b0;
    mem_req_ready = '1;
    wait_idle("bp_idle");

    // Reset two cycles into a load batch; lane 1 has a response in flight.
    lane_addr[0] = 32'h40; lane_addr[1] = 32'h50; resp_val[1] = 32'h5555;
    mem_req_ready = 8'h02;
    exp_hs_q.push_back(mk_hs(1'b0, 1, 32'h50, 32'h0));
    do_start(1'b0, 8'h03);
    tick();
    reset = 1'b1;
    tick();
    check("rst_valids", {mem_req_valid, mem_w_valid}, 16'h0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    tick();
    check("rst_start_ready", start_ready, 1'b1);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_rdata", pack_rdata(), 256'h0);
    repeat (8) tick();
    check("rst_rdata_late", pack_rdata(), 256'h0);

    check("done_count", done_cnt, 4);
    check("hs_queue_empty", exp_hs_q.size(), 0);
    check("done_queue_empty", exp_done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
